// File: rtl/axis_unpack_down.sv
// axis_unpack_down: AXI-Stream width downsizer (IN_W -> OUT_W).
// One wide beat is held and replayed as RATIO narrow words, trimmed to the
// highest word carrying any kept byte, with tlast on the final emitted word.
// Optional macro AXIS_UNPACK_MSW_FIRST_EN: emit the most significant word
// first and trim from the MSW side instead.
module axis_unpack_down #(
  parameter int IN_W  = 128,
  parameter int OUT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_W-1:0]      s_tdata,
  input  logic [IN_W/8-1:0]    s_tkeep,
  input  logic                 s_tlast,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [OUT_W-1:0]     m_tdata,
  output logic [OUT_W/8-1:0]   m_tkeep,
  output logic                 m_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 busy
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int IKW   = IN_W / 8;
  localparam int OKW   = OUT_W / 8;
  // Keep at least one bit so RATIO=1 still has a legal (always zero) index.
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [IN_W-1:0]   data_q,  data_d;
  logic [IKW-1:0]    keep_q,  keep_d;
  logic              last_q,  last_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  // Index of the final word to emit (N-1), computed once at acceptance.
  logic [IDX_W-1:0]  lidx_q,  lidx_d;

  logic [RATIO-1:0]  word_nz;
  logic [IDX_W-1:0]  in_lidx;
  logic [IDX_W-1:0]  sel;
  logic [OUT_W-1:0]  word_data [RATIO];
  logic [OKW-1:0]    word_keep [RATIO];
  logic              at_last;
  logic              accept;

  // Split the incoming keep and the stored beat into per-word lanes.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign word_nz[gi]   = |s_tkeep[gi*OKW +: OKW];
    assign word_data[gi] = data_q[gi*OUT_W +: OUT_W];
    assign word_keep[gi] = keep_q[gi*OKW +: OKW];
  end

  // Last emitted position for the incoming beat; all-zero keep yields 0 (one word).
  always_comb begin
    in_lidx = '0;
`ifdef AXIS_UNPACK_MSW_FIRST_EN
    for (int k = RATIO - 1; k >= 0; k--) begin
      if (word_nz[k]) in_lidx = IDX_W'(RATIO - 1 - k);
    end
`else
    for (int k = 0; k < RATIO; k++) begin
      if (word_nz[k]) in_lidx = IDX_W'(k);
    end
`endif
  end

  // Map emission position to physical lane.
`ifdef AXIS_UNPACK_MSW_FIRST_EN
  assign sel = IDX_W'(RATIO - 1) - idx_q;
`else
  assign sel = idx_q;
`endif

  assign at_last  = (idx_q == lidx_q);
  assign m_tvalid = (state_q == ST_FULL);
  assign busy     = m_tvalid;
  // Ready combinationally on the final word so the next beat loads without a bubble.
  assign s_tready = (state_q == ST_EMPTY) || (m_tready && at_last);
  assign accept   = s_tvalid && s_tready;

  assign m_tdata  = word_data[sel];
  assign m_tkeep  = word_keep[sel];
  assign m_tlast  = (state_q == ST_FULL) && last_q && at_last;

  // Next-state: load a new beat on acceptance, otherwise advance or empty on handshake.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    idx_d   = idx_q;
    lidx_d  = lidx_q;
    if (accept) begin
      state_d = ST_FULL;
      data_d  = s_tdata;
      keep_d  = s_tkeep;
      last_d  = s_tlast;
      idx_d   = '0;
      lidx_d  = in_lidx;
    end else if ((state_q == ST_FULL) && m_tready) begin
      if (at_last) begin
        state_d = ST_EMPTY;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // State registers; an asynchronous reset discards any partially emitted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      lidx_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      lidx_q  <= lidx_d;
    end
  end

endmodule

// File: tb/tb_axis_unpack_down.sv
// Testbench for axis_unpack_down (default 128 -> 32 configuration).
module tb_axis_unpack_down;

  localparam int IN_W  = 128;
  localparam int OUT_W = 32;
  localparam int RATIO = IN_W / OUT_W;

  logic               clk;
  logic               rst_n;
  logic [IN_W-1:0]    s_tdata;
  logic [IN_W/8-1:0]  s_tkeep;
  logic               s_tlast;
  logic               s_tvalid;
  logic               s_tready;
  logic [OUT_W-1:0]   m_tdata;
  logic [OUT_W/8-1:0] m_tkeep;
  logic               m_tlast;
  logic               m_tvalid;
  logic               m_tready;
  logic               busy;

  axis_unpack_down #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected narrow words, queued when a beat is accepted.
  typedef struct {
    logic [OUT_W-1:0]   data;
    logic [OUT_W/8-1:0] keep;
    logic               last;
  } word_t;

  word_t exp_q[$];

  function automatic void push_beat(input logic [IN_W-1:0] d, input logic [IN_W/8-1:0] k,
                                    input logic l);
    int n = 1;
    int lane;
    word_t w;
`ifdef AXIS_UNPACK_MSW_FIRST_EN
    for (int i = RATIO - 1; i >= 0; i--) if (k[i*(OUT_W/8) +: OUT_W/8] != 0) n = RATIO - i;
`else
    for (int i = 0; i < RATIO; i++) if (k[i*(OUT_W/8) +: OUT_W/8] != 0) n = i + 1;
`endif
    for (int j = 0; j < n; j++) begin
`ifdef AXIS_UNPACK_MSW_FIRST_EN
      lane = RATIO - 1 - j;
`else
      lane = j;
`endif
      w.data = d[lane*OUT_W +: OUT_W];
      w.keep = k[lane*(OUT_W/8) +: OUT_W/8];
      w.last = l && (j == n - 1);
      exp_q.push_back(w);
    end
  endfunction

  // Monitor: checks every output handshake, stall stability and busy.
  initial begin : monitor
    logic               stall_pend;
    logic [OUT_W-1:0]   hold_d;
    logic [OUT_W/8-1:0] hold_k;
    logic               hold_l;
    word_t              e;
    stall_pend = 1'b0;
    hold_d = '0; hold_k = '0; hold_l = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        stall_pend = 1'b0;
      end else begin
        chk("busy_eq_valid", busy, m_tvalid);
        if (stall_pend) begin
          chk("stall_valid", m_tvalid, 1'b1);
          chk("stall_stable", {m_tdata, m_tkeep, m_tlast}, {hold_d, hold_k, hold_l});
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", {m_tdata, m_tkeep, m_tlast}, 0);
            if ({m_tdata, m_tkeep, m_tlast} == 0) chk("unexpected_word_valid", m_tvalid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("word", {m_tdata, m_tkeep, m_tlast}, {e.data, e.keep, e.last});
          end
        end
        stall_pend = m_tvalid && !m_tready;
        hold_d = m_tdata; hold_k = m_tkeep; hold_l = m_tlast;
        if (s_tvalid && s_tready) push_beat(s_tdata, s_tkeep, s_tlast);
      end
    end
  end

  // Send one beat with m_tready high and collect what comes out.
  task automatic send_beat(input logic [IN_W-1:0] d, input logic [IN_W/8-1:0] k, input logic l,
                           output int nw, output logic [OUT_W-1:0] ld,
                           output logic [OUT_W/8-1:0] lk, output int nl);
    int guard;
    logic acc;
    nw = 0; nl = 0; ld = '0; lk = '0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1; m_tready = 1'b1;
    guard = 0; acc = 1'b0;
    while (!acc && guard < 20) begin
      @(negedge clk); acc = s_tready;
      @(posedge clk); #1; guard++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    s_tvalid = 1'b0;
    guard = 0;
    while (guard < 20) begin
      @(negedge clk);
      if (!m_tvalid) break;
      nw++; ld = m_tdata; lk = m_tkeep;
      if (m_tlast) nl++;
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [IN_W-1:0]    data;
    logic [IN_W/8-1:0]  keep;
    logic               last;
    int                 n;
    logic [OUT_W-1:0]   ldata;
    logic [OUT_W/8-1:0] lkeep;
    int                 nlast;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #400000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : main
    logic [IN_W-1:0] d1;
    logic [IN_W-1:0] d0;
    int nw, nl, guard, cyc, b;
    logic [OUT_W-1:0] ld;
    logic [OUT_W/8-1:0] lk;
    logic acc, acc_b;
    int pat[8];

    d0 = 128'h33333333_22222222_11111111_00000000;
    d1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    vecs[0] = '{d0, 16'hFFFF, 1'b1, 4, 32'h33333333, 4'hF, 1};
    vecs[1] = '{d1, 16'h00FF, 1'b1, 2, 32'hBBBBBBBB, 4'hF, 1};
    vecs[2] = '{d1, 16'h003F, 1'b1, 2, 32'hBBBBBBBB, 4'h3, 1};
    vecs[3] = '{d1, 16'h0000, 1'b1, 1, 32'hAAAAAAAA, 4'h0, 1};
    vecs[4] = '{d1, 16'hF00F, 1'b0, 4, 32'hDDDDDDDD, 4'hF, 0};
    vecs[5] = '{d1, 16'h0F00, 1'b1, 3, 32'hCCCCCCCC, 4'hF, 1};
    vecs[6] = '{d1, 16'h8000, 1'b0, 4, 32'hDDDDDDDD, 4'h8, 0};
    pat = '{1, 0, 0, 1, 0, 1, 1, 1};

    rst_n = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_s_tready", s_tready, 1'b1);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tlast", m_tlast, 1'b0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tkeep", m_tkeep, 0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;

    // Table-driven single beats.
    for (int i = 0; i < 7; i++) begin
      send_beat(vecs[i].data, vecs[i].keep, vecs[i].last, nw, ld, lk, nl);
      $display("vec %0d keep=%h last=%0d -> words=%0d last_word=%h keep=%h tlasts=%0d",
               i, vecs[i].keep, vecs[i].last, nw, ld, lk, nl);
      chk($sformatf("vec%0d_nwords", i), nw, vecs[i].n);
      chk($sformatf("vec%0d_last_data", i), ld, vecs[i].ldata);
      chk($sformatf("vec%0d_last_keep", i), lk, vecs[i].lkeep);
      chk($sformatf("vec%0d_tlast_count", i), nl, vecs[i].nlast);
    end

    // Back-to-back full beats: 8 contiguous valid cycles, s_tready in cycles 4 and 8.
    s_tdata = d0; s_tkeep = 16'hFFFF; s_tlast = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1;
    guard = 0; acc = 1'b0;
    while (!acc && guard < 20) begin
      @(negedge clk); acc = s_tready;
      @(posedge clk); #1; guard++;
    end
    if (!acc) chk("b2b_accept_timeout", 0, 1);
    s_tdata = d1; s_tlast = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      acc_b = s_tvalid && s_tready;
      $display("b2b cycle %0d valid=%0d s_tready=%0d data=%h", c, m_tvalid, s_tready, m_tdata);
      chk($sformatf("b2b_valid_c%0d", c), m_tvalid, 1'b1);
      chk($sformatf("b2b_sready_c%0d", c), s_tready, (c == 4 || c == 8));
      @(posedge clk); #1;
      if (acc_b) s_tvalid = 1'b0;
    end
    s_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Randomized beats with a fixed then random m_tready stall pattern.
    b = 0; cyc = 0;
    s_tvalid = 1'b0;
    while (b < 40 && cyc < 3000) begin
      if (!s_tvalid) begin
        s_tdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        case ($urandom_range(0, 3))
          0: s_tkeep = 16'hFFFF;
          1: s_tkeep = 16'($urandom());
          2: s_tkeep = 16'hF << (4 * $urandom_range(0, 3));
          default: s_tkeep = (b % 2 == 0) ? 16'h0000 : 16'h0F0F;
        endcase
        s_tlast = 1'($urandom_range(0, 1));
        s_tvalid = (b < 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      m_tready = (cyc < 24) ? (pat[cyc % 8] != 0) : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = s_tvalid && s_tready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        $display("rand beat %0d accepted keep=%h last=%0d cycle=%0d", b, s_tkeep, s_tlast, cyc);
        b++;
        s_tvalid = 1'b0;
      end
    end
    chk("rand_beats_done", b, 40);
    s_tvalid = 1'b0; m_tready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("rand_queue_drained", exp_q.size(), 0);

    // Reset in the middle of a beat.
    s_tdata = d0; s_tkeep = 16'hFFFF; s_tlast = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
    guard = 0; acc = 1'b0;
    while (!acc && guard < 20) begin
      @(negedge clk); acc = s_tready;
      @(posedge clk); #1; guard++;
    end
    if (!acc) chk("rst_accept_timeout", 0, 1);
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("reset mid-beat valid=%0d last=%0d data=%h", m_tvalid, m_tlast, m_tdata);
    chk("midrst_m_tvalid", m_tvalid, 1'b0);
    chk("midrst_m_tlast", m_tlast, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_s_tready", s_tready, 1'b1);
    chk("midrst_m_tdata", m_tdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send_beat(d1, 16'h00FF, 1'b0, nw, ld, lk, nl);
    $display("post-reset beat words=%0d last_word=%h tlasts=%0d", nw, ld, nl);
    chk("postrst_nwords", nw, 2);
    chk("postrst_last_data", ld, 32'hBBBBBBBB);
    chk("postrst_tlast_count", nl, 0);
    chk("postrst_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_unpack_down.md
Name: axis_unpack_down

Overview:
- Reader-side width downsizer for the AES datapath; consumes wide AXI-Stream beats (typically the 128-bit output of the block FIFO) and emits them as narrow words for a 32-bit host or DMA port.
- Honours tkeep: trailing unused words of a beat are not emitted.
- Forwards tlast on the final emitted word of a beat.
- One-beat holding buffer; sustains full narrow-side throughput with no bubbles between beats.

Parameters:
- IN_W, 128, input data width in bits; must be an integer multiple of OUT_W.
- OUT_W, 32, output data width in bits; multiple of 8.
- RATIO, IN_W/OUT_W, words per input beat; derived, not overridden.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- s_tdata  input  IN_W  wide beat data
- s_tkeep  input  IN_W/8  byte qualifiers for s_tdata
- s_tlast  input  1  end of packet
- s_tvalid  input  1  beat valid
- s_tready  output  1  beat accepted when s_tvalid && s_tready
- m_tdata  output  OUT_W  narrow word data
- m_tkeep  output  OUT_W/8  byte qualifiers for the word
- m_tlast  output  1  last word of packet
- m_tvalid  output  1  word valid
- m_tready  input  1  downstream ready
- busy  output  1  holding buffer occupied (equal to m_tvalid)

Behaviour:
- Clock and reset: clk drives all state; rst_n is asynchronous and active-low.
- Reset values:
  - m_tvalid=0, busy=0, m_tdata=0, m_tkeep=0, m_tlast=0, word index=0.
  - s_tready=1 in the first cycle after reset release.
- Lane order: word k = s_tdata[k*OUT_W +: OUT_W], with keep s_tkeep[k*OUT_W/8 +: OUT_W/8]. Word 0 is emitted first.
- Word count per beat: N = 1 + highest k whose keep slice is nonzero.
  - Interior words with zero keep are still emitted, carrying keep 0.
  - If all of s_tkeep is 0, N=1: a single word with m_tkeep=0 and m_tlast=s_tlast.
- States:
  - EMPTY (m_tvalid=0):
    - s_tready=1.
    - On acceptance: capture data, keep, last and N; index=0; go to FULL.
  - FULL (m_tvalid=1):
    - Outputs present word[index] and its keep slice.
    - m_tlast = stored_last && (index==N-1).
    - On m_tready with index<N-1: index+1.
    - On m_tready with index==N-1: see the last-word rules below.
- Last-word handshake:
  - s_tready = !m_tvalid || (m_tready && index==N-1); this is combinational from m_tready.
  - A simultaneous final-word handshake and new input acceptance loads the new beat with index=0, staying in FULL with no bubble.
  - Final-word handshake without a new beat: go to EMPTY.
- Latency and throughput:
  - First word is valid the cycle after input acceptance.
  - A full beat takes RATIO output cycles when m_tready is held high.
- Stability:
  - m_tdata, m_tkeep and m_tlast are stable while m_tvalid && !m_tready.
  - m_tvalid never deasserts without a handshake.
- Stored beat: the holding buffer is sampled only at acceptance; s_tdata changes while FULL are ignored.
- Reset mid-beat: remaining words are discarded, state returns to EMPTY, and no partial tlast is emitted.
- Index register is $clog2(RATIO) bits wide; RATIO=1 degenerates to a registered pass-through slice.

Optional Feature:
- Macro: AXIS_UNPACK_MSW_FIRST_EN.
- Defined:
  - Word order is reversed: word RATIO-1 (MSW) is emitted first.
  - N counts from the MSW side: N = RATIO - lowest k with nonzero keep slice.
  - The all-zero-keep rule is unchanged.
- Undefined: LSW-first order as specified above.

Test Plan:
- Reset release -> s_tready=1, m_tvalid=0, m_tlast=0 on the first clk edge.
- One beat s_tdata=0x33333333_22222222_11111111_00000000, s_tkeep=0xFFFF, s_tlast=1, m_tready=1:
  - m_tdata 0x00000000, 0x11111111, 0x22222222, 0x33333333 on consecutive cycles.
  - m_tlast only on 0x33333333.
  - m_tkeep=0xF on all four words.
- Partial beat s_tkeep=0x00FF, s_tlast=1 -> exactly 2 words emitted, m_tlast on word 1; s_tkeep=0x003F -> 2 words, the second with m_tkeep=0x3.
- Two back-to-back full beats with m_tready=1 -> 8 contiguous valid cycles with no bubble; s_tready high in cycles 4 and 8 only.
- Random m_tready stalls (pattern 1,0,0,1,0,1,1,1) over three beats -> data, keep and last held stable during stalls; word sequence matches a reference model.
- Assert rst_n=0 after the second word of a beat -> m_tvalid=0 immediately; after release the next beat starts at word 0 with no stale tlast.
